// File: rtl/seq_cmp.sv
// seq_cmp: multi-cycle magnitude/equality comparator.
// Operands are compared CHUNK bits per cycle, most significant chunk first.
// Signed mode flips the sign bit of both operands on capture (offset binary)
// so that the chunk-by-chunk unsigned scan also orders two's-complement values.
// EARLY_EXIT=1 stops on the first differing chunk; EARLY_EXIT=0 always scans
// every chunk, giving constant latency, and keeps the first difference sticky.
module seq_cmp #(
    parameter int WIDTH      = 16,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1,
    localparam int NCHUNK    = WIDTH / CHUNK,
    localparam int CW        = $clog2(NCHUNK) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             ready,
    output logic             done,
    output logic             aeqb,
    output logic             agtb,
    output logic             altb,
    output logic [CW-1:0]    cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0]    LAST_IDX  = CW'(NCHUNK - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam bit               EE        = (EARLY_EXIT != 0);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  ra_q, ra_d;
    logic [WIDTH-1:0]  rb_q, rb_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              gt_q, gt_d;
    logic              lt_q, lt_d;
    logic              aeqb_q, aeqb_d;
    logic              agtb_q, agtb_d;
    logic              altb_q, altb_d;
    logic [CW-1:0]     cycles_q, cycles_d;

    logic [CHUNK-1:0]  top_a_s;
    logic [CHUNK-1:0]  top_b_s;
    logic              chunk_gt_s;
    logic              chunk_lt_s;
    logic              last_s;
    logic              finish_s;
    logic              fin_gt_s;
    logic              fin_lt_s;
    logic              ready_s;
    logic              done_s;

    // Current chunk comparison and the decision whether this is the final compare.
    always_comb begin
        top_a_s    = ra_q[WIDTH-1 -: CHUNK];
        top_b_s    = rb_q[WIDTH-1 -: CHUNK];
        chunk_gt_s = (top_a_s > top_b_s);
        chunk_lt_s = (top_a_s < top_b_s);
        last_s     = (cnt_q == LAST_IDX);
        // The first difference wins; later chunks cannot override a set flag.
        fin_gt_s   = gt_q | (~lt_q & chunk_gt_s);
        fin_lt_s   = lt_q | (~gt_q & chunk_lt_s);
        finish_s   = last_s | (EE & (chunk_gt_s | chunk_lt_s));
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CMP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMP: begin
                if (finish_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CMP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        ready_s = 1'b0;
        done_s  = 1'b0;
        case (state_q)
            S_IDLE:  ready_s = 1'b1;
            S_CMP:   ready_s = 1'b0;
            S_DONE:  done_s  = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    // Datapath next values: operand capture, chunk shifting, sticky flags, result load.
    always_comb begin
        ra_d     = ra_q;
        rb_d     = rb_q;
        cnt_d    = cnt_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        aeqb_d   = aeqb_q;
        agtb_d   = agtb_q;
        altb_d   = altb_q;
        cycles_d = cycles_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (signed_mode) begin
                        ra_d = a ^ SIGN_MASK;
                        rb_d = b ^ SIGN_MASK;
                    end else begin
                        ra_d = a;
                        rb_d = b;
                    end
                    cnt_d = '0;
                    gt_d  = 1'b0;
                    lt_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_CMP: begin
                cnt_d = cnt_q + CNT_ONE;
                gt_d  = fin_gt_s;
                lt_d  = fin_lt_s;
                ra_d  = ra_q << CHUNK;
                rb_d  = rb_q << CHUNK;
                if (finish_s) begin
                    agtb_d   = fin_gt_s;
                    altb_d   = fin_lt_s;
                    aeqb_d   = ~(fin_gt_s | fin_lt_s);
                    cycles_d = cnt_q + CNT_ONE;
                end else begin
                    cycles_d = cycles_q;
                end
            end
            S_DONE:  cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    // Datapath and result registers; reset clears everything including held results.
    always_ff @(posedge clk) begin
        if (reset) begin
            ra_q     <= '0;
            rb_q     <= '0;
            cnt_q    <= '0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            aeqb_q   <= 1'b0;
            agtb_q   <= 1'b0;
            altb_q   <= 1'b0;
            cycles_q <= '0;
        end else begin
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            cnt_q    <= cnt_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            aeqb_q   <= aeqb_d;
            agtb_q   <= agtb_d;
            altb_q   <= altb_d;
            cycles_q <= cycles_d;
        end
    end

    assign ready  = ready_s;
    assign done   = done_s;
    assign aeqb   = aeqb_q;
    assign agtb   = agtb_q;
    assign altb   = altb_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_seq_cmp.sv
// Testbench for seq_cmp: three instances (16/4 early exit, 16/4 full scan,
// 16/16 single chunk) checked against an arithmetic reference model.
module tb_seq_cmp;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  st;
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;

    logic [2:0]  rdy, dn, eq, gt, lt;
    logic [2:0]  cyc0, cyc1;
    logic [0:0]  cyc2;

    int checks   = 0;
    int failures = 0;
    logic [31:0] prev_flags0 = 32'd0;

    // Free-running clock.
    always #5 clk = ~clk;

    seq_cmp #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) u0 (
        .clk(clk), .reset(reset), .start(st[0]), .a(a), .b(b), .signed_mode(sm),
        .ready(rdy[0]), .done(dn[0]), .aeqb(eq[0]), .agtb(gt[0]), .altb(lt[0]), .cycles(cyc0));
    seq_cmp #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) u1 (
        .clk(clk), .reset(reset), .start(st[1]), .a(a), .b(b), .signed_mode(sm),
        .ready(rdy[1]), .done(dn[1]), .aeqb(eq[1]), .agtb(gt[1]), .altb(lt[1]), .cycles(cyc1));
    seq_cmp #(.WIDTH(16), .CHUNK(16), .EARLY_EXIT(1)) u2 (
        .clk(clk), .reset(reset), .start(st[2]), .a(a), .b(b), .signed_mode(sm),
        .ready(rdy[2]), .done(dn[2]), .aeqb(eq[2]), .agtb(gt[2]), .altb(lt[2]), .cycles(cyc2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cyc_of(input int i);
        case (i)
            0:       return {29'd0, cyc0};
            1:       return {29'd0, cyc1};
            default: return {31'd0, cyc2};
        endcase
    endfunction

    function automatic logic [31:0] flags_of(input int i);
        return {29'd0, eq[i], gt[i], lt[i]};
    endfunction

    // Reference: ordering from plain (signed) arithmetic; latency = index of the
    // first non-zero chunk of a^b counted from the MSB, or the chunk count.
    task automatic ref_cmp(input logic [15:0] x, input logic [15:0] y, input logic s,
                           input int chunk, input int ee,
                           output logic [31:0] flags, output int k);
        int nch;
        int d;
        bit found;
        nch = 16 / chunk;
        d   = int'(x ^ y);
        if (x == y)                                    flags = 32'd4;
        else if (s ? ($signed(x) > $signed(y)) : (x > y)) flags = 32'd2;
        else                                           flags = 32'd1;
        k = nch;
        found = 1'b0;
        if (ee != 0) begin
            for (int i = 0; i < nch; i++) begin
                if (!found && (((d >> (16 - (i + 1) * chunk)) & ((1 << chunk) - 1)) != 0)) begin
                    k = i + 1;
                    found = 1'b1;
                end
            end
        end
    endtask

    // One operation on the instances selected by msk. Entered and left at a
    // negedge; on exit every selected instance is back in its first IDLE cycle.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                         input logic [2:0] msk, input bit inject, input bit hold);
        logic [31:0] ef[3];
        int k[3];
        int lat[3];
        int npulse[3];
        int chunks[3];
        int ees[3];
        int stop_at;
        bit all_done;
        chunks = '{4, 4, 16};
        ees    = '{1, 0, 1};
        stop_at = -1;
        for (int i = 0; i < 3; i++) begin
            ref_cmp(x, y, s, chunks[i], ees[i], ef[i], k[i]);
            lat[i] = 0;
            npulse[i] = 0;
            if (msk[i]) check($sformatf("u%0d_ready_before", i), {31'd0, rdy[i]}, 32'd1);
        end
        a = x; b = y; sm = s; st = msk;
        @(posedge clk);
        @(negedge clk);
        st = 3'b000;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (inject) begin
                if (n == 1) begin
                    st = 3'b001;
                    a = ~x;
                    b = x;
                    sm = ~s;
                end else begin
                    st = 3'b000;
                end
            end
            all_done = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (msk[i]) begin
                    if (dn[i]) begin
                        npulse[i]++;
                        if (lat[i] == 0) lat[i] = n;
                    end
                    if (lat[i] == 0) all_done = 1'b0;
                end
            end
            if (hold && msk[0] && lat[0] == 0)
                check("u0_result_held", flags_of(0), prev_flags0);
            if (all_done && stop_at < 0) stop_at = n + 1;
            if (n == stop_at) break;
        end
        for (int i = 0; i < 3; i++) begin
            if (msk[i]) begin
                check($sformatf("u%0d_latency", i), lat[i], k[i]);
                check($sformatf("u%0d_done_pulses", i), npulse[i], 32'd1);
                check($sformatf("u%0d_flags", i), flags_of(i), ef[i]);
                check($sformatf("u%0d_cycles", i), cyc_of(i), k[i]);
                check($sformatf("u%0d_ready_after", i), {31'd0, rdy[i]}, 32'd1);
            end
        end
        if (msk[0]) prev_flags0 = ef[0];
    endtask

    initial begin
        logic [15:0] x, y, one;
        logic s;
        one = 16'h0001;
        reset = 1'b1; st = 3'b000; a = 16'h0000; b = 16'h0000; sm = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_rst_ready", i), {31'd0, rdy[i]}, 32'd1);
            check($sformatf("u%0d_rst_done", i), {31'd0, dn[i]}, 32'd0);
            check($sformatf("u%0d_rst_flags", i), flags_of(i), 32'd0);
            check($sformatf("u%0d_rst_cycles", i), cyc_of(i), 32'd0);
        end

        // Directed cases.
        do_op(16'hA5A5, 16'hA5A5, 1'b0, 3'b111, 1'b0, 1'b0);
        do_op(16'h8000, 16'h7FFF, 1'b0, 3'b111, 1'b0, 1'b0);
        do_op(16'h8000, 16'h7FFF, 1'b1, 3'b111, 1'b0, 1'b0);
        do_op(16'h1234, 16'h1235, 1'b0, 3'b111, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'hFFFE, 1'b1, 3'b111, 1'b0, 1'b0);
        do_op(16'hF000, 16'h0000, 1'b0, 3'b111, 1'b0, 1'b0);
        do_op(16'h0000, 16'hF000, 1'b1, 3'b111, 1'b0, 1'b0);

        // Randomised operations.
        for (int t = 0; t < 60; t++) begin
            x = 16'($urandom);
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       y = x;
                1:       y = x ^ (one << $urandom_range(0, 15));
                default: y = 16'($urandom);
            endcase
            do_op(x, y, s, 3'b111, 1'b0, 1'b0);
        end

        // Start during CMP is ignored.
        do_op(16'h1111, 16'h1111, 1'b0, 3'b001, 1'b1, 1'b0);

        // Back-to-back on u0: prior result held until the new done.
        do_op(16'h0001, 16'h0002, 1'b0, 3'b001, 1'b0, 1'b0);
        do_op(16'h0300, 16'h0200, 1'b0, 3'b001, 1'b0, 1'b1);

        // Reset in the second CMP cycle aborts the operation.
        a = 16'h4444; b = 16'h4444; sm = 1'b0; st = 3'b001;
        @(posedge clk);
        @(negedge clk);
        st = 3'b000;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_done", {31'd0, dn[0]}, 32'd0);
        check("abort_flags", flags_of(0), 32'd0);
        check("abort_cycles", cyc_of(0), 32'd0);
        check("abort_ready", {31'd0, rdy[0]}, 32'd1);
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_no_done", {31'd0, dn[0]}, 32'd0);
        end

        // Reset and start together: start is not accepted.
        reset = 1'b1; st = 3'b001; a = 16'h0001; b = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; st = 3'b000;
        @(posedge clk);
        @(negedge clk);
        check("rst_start_ready", {31'd0, rdy[0]}, 32'd1);
        check("rst_start_flags", flags_of(0), 32'd0);

        // Normal operation afterwards.
        do_op(16'h00F0, 16'h00F0, 1'b1, 3'b111, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_cmp.md
Name: seq_cmp

Overview:
Parametrised multi-cycle magnitude/equality comparator, successor to the 2-bit combinational equality block. Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, and reports equal / greater / less. Supports signed or unsigned mode per operation, early exit on the first differing chunk, and a start/ready/done handshake. Used where wide operand comparison must not sit in one combinational path.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
EARLY_EXIT, 1, 1 = finish on first differing chunk; 0 = always scan all chunks (constant latency).
Derived: NCHUNK = WIDTH/CHUNK; CW = clog2(NCHUNK)+1.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; accepted only when ready=1
a  in  WIDTH  operand A, sampled on accepted start
b  in  WIDTH  operand B, sampled on accepted start
signed_mode  in  1  1 = two's-complement compare; sampled on accepted start
ready  out  1  high only in IDLE
done  out  1  one-cycle pulse, result valid
aeqb  out  1  A == B
agtb  out  1  A > B
altb  out  1  A < B
cycles  out  CW  number of chunk compares performed for the last result

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). No other clocks or async paths.
- Reset: state=IDLE; ready=1, done=0, aeqb=agtb=altb=0, cycles=0; internal shift registers cleared.
- FSM states: IDLE, CMP, DONE.
- IDLE: ready=1. On start=1, latch a,b into shift regs ra,rb. If signed_mode=1, invert bit WIDTH-1 of both (offset-binary), so the compare is unsigned from then on. Clear the difference flags and the compare counter, then go to CMP. start while not IDLE is ignored: no queueing, no effect.
- CMP, each cycle: compare top chunks ra[WIDTH-1 -: CHUNK] vs rb[...] unsigned; counter increments.
  - EARLY_EXIT=1:
    - top chunks differ -> record gt/lt, go to DONE.
    - top chunks equal and last chunk -> record eq, go to DONE.
    - otherwise shift ra,rb left by CHUNK and stay in CMP.
  - EARLY_EXIT=0:
    - first differing chunk sets a sticky gt/lt flag; later chunks do not change it.
    - always stay exactly NCHUNK compare cycles.
    - at the end the result is eq if no flag was set.
- Result regs aeqb/agtb/altb/cycles: load on the edge entering DONE. Exactly one of the three flags is 1. Values hold until the next result loads; they are not cleared on a new start.
- DONE: done=1 for exactly one cycle, ready=0, then go to IDLE unconditionally.
- Latency: start accepted at edge E0; k compare edges follow; done is high in the cycle after edge Ek. k = index of the first differing chunk (1..NCHUNK) with early exit, else NCHUNK. Earliest next start is accepted at edge Ek+1 (IDLE re-entered).
- Boundaries:
  - CHUNK=WIDTH -> single-cycle compare, k=1 always.
  - Operands equal -> k=NCHUNK in both modes.
  - In signed mode, sign difference is decided in chunk 1.
- Reset mid-operation (CMP or DONE): abort, no done pulse, all outputs return to reset values.
- reset and start in the same cycle: reset wins; start is not accepted.

Test Plan:
Default instance (WIDTH=16, CHUNK=4, EARLY_EXIT=1) unless stated.
1. Reset release -> ready=1, done=0, aeqb=agtb=altb=0, cycles=0. Then start, a=b=16'hA5A5, unsigned -> done exactly 4 cycles after the accept edge, aeqb=1, cycles=4.
2. Unsigned a=16'h8000, b=16'h7FFF -> done 1 cycle after accept, agtb=1, cycles=1. Repeat with signed_mode=1 -> altb=1, cycles=1.
3. Unsigned a=16'h1234, b=16'h1235 -> altb=1, cycles=4. Signed a=16'hFFFF (-1), b=16'hFFFE (-2) -> agtb=1, cycles=4.
4. EARLY_EXIT=0 instance, a=16'hF000, b=16'h0000 -> agtb=1, cycles=4, done 4 cycles after accept. Compare with the EARLY_EXIT=1 instance: done after 1 cycle.
5. Pulse start with new operands during CMP -> ignored; the result matches the original operands. Assert reset in the 2nd CMP cycle -> no done pulse, all outputs 0, ready=1 next cycle.
6. Back-to-back: assert start in the first IDLE cycle after done -> accepted. The prior result stays on aeqb/agtb/altb until the new done. CHUNK=16 instance: any operands -> cycles=1.
